// File: rtl/histogram_pixel_feeder.sv
// histogram_pixel_feeder
// Front end of the histogram/CDF path. Each frame runs as a sequence:
// clear the counter bank, count the accepted pixels, then pulse frame_done
// once the last bank increment has landed. Each accepted pixel intensity is
// decoded into a one-hot, single-cycle enable for the counter bank.
// Every output is registered.
module histogram_pixel_feeder #(
    parameter int PIX_W        = 8,
    parameter int BINS         = 256,
    parameter int CNT_W        = 15,
    parameter int FRAME_PIXELS = 16384
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    output logic             pix_ready,
    output logic             counter_clear,
    output logic [BINS-1:0]  counter_en,
    output logic [CNT_W-1:0] pix_count,
    output logic             busy,
    output logic             frame_done,
    output logic             short_frame
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLR   = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Index of the last pixel a frame may hold, and the frame size with one
    // extra bit so that pix_count+1 can be compared without wrapping.
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W:0]   FRAME_LIMIT = (CNT_W + 1)'(FRAME_PIXELS);

    logic [1:0]     state_r;
    logic [1:0]     next_state_s;
    logic           accept_s;
    logic           frame_end_s;
    logic           start_frame_s;
    logic [CNT_W:0] count_inc_s;

    // Decodes an intensity into the enable of its bin.
    function automatic logic [BINS-1:0] onehot(input logic [PIX_W-1:0] idx);
        logic [BINS-1:0] v;
        v      = {BINS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Handshake and frame-end qualification for the current cycle.
    always_comb begin
        accept_s      = pix_valid & pix_ready & (state_r == S_ACCUM);
        frame_end_s   = accept_s & (pix_last | (pix_count == LAST_IDX));
        start_frame_s = (state_r == S_IDLE) & start;
        count_inc_s   = {1'b0, pix_count} + {{CNT_W{1'b0}}, 1'b1};
    end

    // Next-state logic. Abort wins over frame end. Start is seen only in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_CLR;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CLR: begin
                if (abort) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (abort) begin
                    next_state_s = S_IDLE;
                end else if (frame_end_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_ACCUM;
                end
            end
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State register. Status outputs are registered from the next state, so
    // each one lines up exactly with the state it describes.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r       <= S_IDLE;
            pix_ready     <= 1'b0;
            busy          <= 1'b0;
            counter_clear <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pix_ready     <= (next_state_s == S_ACCUM);
            busy          <= (next_state_s != S_IDLE);
            counter_clear <= (next_state_s == S_CLR);
        end
    end

    // Bank enable is valid for the cycle after an accept only. An abort
    // cancels the enable for a pixel offered in the same cycle.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            counter_en <= {BINS{1'b0}};
        end else if (accept_s && !abort) begin
            counter_en <= onehot(pix_data);
        end else begin
            counter_en <= {BINS{1'b0}};
        end
    end

    // The frame_done pulse is raised on the way out of DONE. By then the
    // final increment has been presented to the bank.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state_r == S_DONE) & ~abort;
        end
    end

    // Pixel counter and short-frame flag. Both are cleared by start and
    // otherwise hold through IDLE, so software can read the last frame.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pix_count   <= {CNT_W{1'b0}};
            short_frame <= 1'b0;
        end else if (start_frame_s) begin
            pix_count   <= {CNT_W{1'b0}};
            short_frame <= 1'b0;
        end else if (accept_s && !abort) begin
            pix_count <= count_inc_s[CNT_W-1:0];
            if (frame_end_s) begin
                short_frame <= pix_last & (count_inc_s < FRAME_LIMIT);
            end else begin
                short_frame <= short_frame;
            end
        end else begin
            pix_count   <= pix_count;
            short_frame <= short_frame;
        end
    end

endmodule
